ahb_gpio_irq: RTL and testbench
===============================

# ahb_gpio_irq

Parametrised AHB-Lite GPIO peripheral with per-bit direction control, atomic set/clear of outputs, input synchronisation and edge-triggered interrupts. It replaces the fixed-width, poll-only GPIO path in the camera/GPIO subsystem. It decodes its own AHB-Lite slave port with zero wait states and drives a single level interrupt to the processor.

## Interface
- IO_WIDTH, 8: number of GPIO bits, 1..32.
- SYNC_STAGES, 2: input synchroniser depth, 2..4.
- clk  in  1  system clock; everything is synchronous to it.
- resetn  in  1  asynchronous, active-low reset.
- ahb_s0_hsel_i  in  1  slave select.
- ahb_s0_haddr_i  in  32  address; only [5:2] are decoded.
- ahb_s0_hwrite_i  in  1  write when high.
- ahb_s0_hsize_i  in  3  transfer size; only 3'b010 (word) writes take effect.
- ahb_s0_htrans_i  in  2  a transfer is valid when htrans[1]=1.
- ahb_s0_hwdata_i  in  32  write data (data phase).
- ahb_s0_hready_o  out  1  constant 1.
- ahb_s0_hresp_o  out  1  constant 0 (OKAY).
- ahb_s0_hrdata_o  out  32  read data (data phase).
- ext_input_io  in  IO_WIDTH  asynchronous pin inputs.
- ext_output_io  out  IO_WIDTH  pin output values.
- ext_oe_o  out  IO_WIDTH  per-bit output enable; 1 = drive.
- irq_o  out  1  level interrupt.

## Operation
- Address phase: when hsel & htrans[1] & hready, register the valid flag, hwrite, haddr[5:2] and the hsize-is-word flag. The following data phase uses only these registered values.
- Register map (word offsets, bits above IO_WIDTH read 0, all reset 0):
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write.
  - 0x08 IN: read-only, synchronised pins.
  - 0x0C IRQ_EN: read/write.
  - 0x10 RISE_EN: read/write.
  - 0x14 FALL_EN: read/write.
  - 0x18 STATUS: read, write-1-to-clear.
  - 0x1C OUT_SET: write-only (OUT |= wdata), reads 0.
  - 0x20 OUT_CLR: write-only (OUT &= ~wdata), reads 0.
  - Other offsets: reads return 0, writes are ignored.
- Writes update the register at the clock edge that ends the data phase. Sub-word writes are ignored.
- Reads: hrdata is a combinational mux over the registered data-phase address. It is 0 when no read data phase is active.
- Input path: SYNC_STAGES flops give sync. A further flop gives prev.
  - rise = sync & ~prev
  - fall = ~sync & prev
- STATUS next = (STATUS & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN). If an edge and a W1C hit the same bit in the same cycle, the set wins.
- STATUS latches edges regardless of IRQ_EN. IRQ_EN only masks irq_o.
- irq_o is registered: irq_o <= |(STATUS & IRQ_EN).
- ext_output_io = OUT and ext_oe_o = DIR. Pins read back through IN regardless of DIR.
- Spurious edges after reset: the synchroniser and prev reset to 0. RISE_EN and FALL_EN also reset to 0, so no edge is recorded until software enables it.

## Timing
- Reset values: ext_output_io=0, ext_oe_o=0, irq_o=0, hrdata=0, hready=1, hresp=0. All registers and pipeline flops are 0.
- Read latency is zero wait states: data is valid in the data phase.
- Back-to-back write then read of the same register: the read's data phase follows the write edge, so it returns the new value. No forwarding is needed.
- Pin change to IN visible: SYNC_STAGES edges.
- Pin change to STATUS set: SYNC_STAGES+1 edges.
- Pin change to irq_o high: SYNC_STAGES+2 edges.
- W1C of the last pending enabled bit: irq_o falls one edge after the write edge.
- Reset asserted mid-transfer: all state clears immediately. The pending data phase is dropped.

## Structure
- Package gpio_irq_pkg holds the register offset localparams (OFS_OUT … OFS_OUT_CLR) and a typedef for the registered address-phase struct (valid, write, word, idx[3:0]).
- One sub-module, gpio_sync_edge: parametrised by IO_WIDTH and SYNC_STAGES, it outputs sync, rise and fall.

## Test plan
- Reset, then read all offsets: every read returns 0, and irq_o=0 and ext_oe_o=0.
- Write OUT=0xA5 and DIR=0x0F, then OUT_SET=0x10 and OUT_CLR=0x01:
  - ext_output_io=0xB4 and ext_oe_o=0x0F.
  - Reading OUT returns 0xB4.
  - A halfword write to OUT has no effect.
- RISE_EN=0x01 and IRQ_EN=0x01, pin0 driven 0→1:
  - STATUS=0x01 after 3 edges.
  - irq_o goes high after 4 edges (SYNC_STAGES=2).
  - Writing STATUS=0x01 drops irq_o one edge later.
- FALL_EN=0x02 with IRQ_EN=0, pin1 driven 1→0: STATUS[1]=1 and irq_o stays 0. Setting IRQ_EN=0x02 raises irq_o one edge after the write.
- W1C of bit0 in the same cycle as a new rising edge on pin0: STATUS[0] stays 1 and irq_o stays high.
- Back-to-back write DIR=0x3C then read DIR, and a read of offset 0x24: they return 0x3C and 0 respectively. hready is 1 throughout.

Source files
------------

// File: rtl/gpio_irq_pkg.sv
// Shared definitions for the AHB-Lite GPIO peripheral with edge interrupts.
// Holds the register word offsets (haddr[5:2]), the word transfer size
// and the layout of the registered address-phase information.
package gpio_irq_pkg;

  // Word index of each register, i.e. byte offset >> 2.
  localparam logic [3:0] OFS_OUT     = 4'h0;
  localparam logic [3:0] OFS_DIR     = 4'h1;
  localparam logic [3:0] OFS_IN      = 4'h2;
  localparam logic [3:0] OFS_IRQ_EN  = 4'h3;
  localparam logic [3:0] OFS_RISE_EN = 4'h4;
  localparam logic [3:0] OFS_FALL_EN = 4'h5;
  localparam logic [3:0] OFS_STATUS  = 4'h6;
  localparam logic [3:0] OFS_OUT_SET = 4'h7;
  localparam logic [3:0] OFS_OUT_CLR = 4'h8;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Address-phase information carried into the data phase.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       word;
    logic [3:0] idx;
  } aphase_t;

endpackage

// File: rtl/gpio_sync_edge.sv
// Input synchroniser and edge detector for the GPIO pins.
// Ports:
//   clk, resetn : clock and asynchronous active-low reset
//   pin         : asynchronous pin inputs
//   sync        : pins after SYNC_STAGES flops
//   rise, fall  : one-cycle pulses on a 0->1 / 1->0 transition of sync
module gpio_sync_edge #(
  parameter int unsigned IO_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [IO_WIDTH-1:0] pin,
  output logic [IO_WIDTH-1:0] sync,
  output logic [IO_WIDTH-1:0] rise,
  output logic [IO_WIDTH-1:0] fall
);

  logic [IO_WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [IO_WIDTH-1:0] prev_q;

  // Everything resets to 0 so a high pin after reset looks like a rise,
  // which is harmless because the edge enables also reset to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= pin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO peripheral: per-bit direction, atomic set/clear of outputs,
// synchronised inputs and edge-triggered level interrupt. Zero wait states.
// Ports:
//   clk, resetn        : clock and asynchronous active-low reset
//   ahb_s0_*           : AHB-Lite slave port (hready always 1, hresp always OKAY)
//   ext_input_io       : asynchronous pin inputs
//   ext_output_io      : pin output values (OUT register)
//   ext_oe_o           : per-bit output enable (DIR register)
//   irq_o              : registered level interrupt, |(STATUS & IRQ_EN)
module ahb_gpio_irq
  import gpio_irq_pkg::*;
#(
  parameter int unsigned IO_WIDTH    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                ahb_s0_hsel_i,
  input  logic [31:0]         ahb_s0_haddr_i,
  input  logic                ahb_s0_hwrite_i,
  input  logic [2:0]          ahb_s0_hsize_i,
  input  logic [1:0]          ahb_s0_htrans_i,
  input  logic [31:0]         ahb_s0_hwdata_i,
  output logic                ahb_s0_hready_o,
  output logic                ahb_s0_hresp_o,
  output logic [31:0]         ahb_s0_hrdata_o,
  input  logic [IO_WIDTH-1:0] ext_input_io,
  output logic [IO_WIDTH-1:0] ext_output_io,
  output logic [IO_WIDTH-1:0] ext_oe_o,
  output logic                irq_o
);

  aphase_t aphase_d, dphase_q;

  logic [IO_WIDTH-1:0] out_q, out_d;
  logic [IO_WIDTH-1:0] dir_q, dir_d;
  logic [IO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [IO_WIDTH-1:0] rise_en_q, rise_en_d;
  logic [IO_WIDTH-1:0] fall_en_q, fall_en_d;
  logic [IO_WIDTH-1:0] status_q, status_d;
  logic [IO_WIDTH-1:0] w1c_mask;
  logic [IO_WIDTH-1:0] rd_val;
  logic [IO_WIDTH-1:0] wdata;
  logic [IO_WIDTH-1:0] pin_sync, pin_rise, pin_fall;
  logic                wr_en;
  logic                rd_en;
  logic                irq_q;
  logic                unused_bits;

  gpio_sync_edge #(
    .IO_WIDTH   (IO_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .resetn(resetn),
    .pin   (ext_input_io),
    .sync  (pin_sync),
    .rise  (pin_rise),
    .fall  (pin_fall)
  );

  // hready is tied high, so every selected non-idle transfer is accepted.
  always_comb begin
    aphase_d.valid = ahb_s0_hsel_i & ahb_s0_htrans_i[1];
    aphase_d.write = ahb_s0_hwrite_i;
    aphase_d.word  = (ahb_s0_hsize_i == HSIZE_WORD);
    aphase_d.idx   = ahb_s0_haddr_i[5:2];
  end

  assign wr_en = dphase_q.valid & dphase_q.write & dphase_q.word;
  assign rd_en = dphase_q.valid & ~dphase_q.write;
  assign wdata = ahb_s0_hwdata_i[IO_WIDTH-1:0];

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c_mask  = '0;
    if (wr_en) begin
      case (dphase_q.idx)
        OFS_OUT:     out_d     = wdata;
        OFS_DIR:     dir_d     = wdata;
        OFS_IRQ_EN:  irq_en_d  = wdata;
        OFS_RISE_EN: rise_en_d = wdata;
        OFS_FALL_EN: fall_en_d = wdata;
        OFS_STATUS:  w1c_mask  = wdata;
        OFS_OUT_SET: out_d     = out_q | wdata;
        OFS_OUT_CLR: out_d     = out_q & ~wdata;
        default:     ;
      endcase
    end
    // Set terms are ORed in after the clear so a coincident edge wins.
    status_d = (status_q & ~w1c_mask) | (pin_rise & rise_en_q) | (pin_fall & fall_en_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dphase_q  <= '0;
      out_q     <= '0;
      dir_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      dphase_q  <= aphase_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      irq_en_q  <= irq_en_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      irq_q     <= |(status_q & irq_en_q);
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_en) begin
      case (dphase_q.idx)
        OFS_OUT:     rd_val = out_q;
        OFS_DIR:     rd_val = dir_q;
        OFS_IN:      rd_val = pin_sync;
        OFS_IRQ_EN:  rd_val = irq_en_q;
        OFS_RISE_EN: rd_val = rise_en_q;
        OFS_FALL_EN: rd_val = fall_en_q;
        OFS_STATUS:  rd_val = status_q;
        default:     rd_val = '0;
      endcase
    end
  end

  // Zero-extend so IO_WIDTH = 32 needs no special case.
  always_comb begin
    ahb_s0_hrdata_o                 = '0;
    ahb_s0_hrdata_o[IO_WIDTH-1:0]   = rd_val;
  end

  assign ahb_s0_hready_o = 1'b1;
  assign ahb_s0_hresp_o  = 1'b0;
  assign ext_output_io   = out_q;
  assign ext_oe_o        = dir_q;
  assign irq_o           = irq_q;

  assign unused_bits = ^{ahb_s0_haddr_i[31:6], ahb_s0_haddr_i[1:0], ahb_s0_hwdata_i};

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Directed self-checking bench for ahb_gpio_irq (IO_WIDTH=8, SYNC_STAGES=2).
module tb_ahb_gpio_irq;

  logic        clk = 1'b0;
  logic        resetn;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [7:0]  ext_in;
  logic [7:0]  ext_out;
  logic [7:0]  ext_oe;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  ahb_gpio_irq #(
    .IO_WIDTH   (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ahb_s0_hsel_i  (hsel),
    .ahb_s0_haddr_i (haddr),
    .ahb_s0_hwrite_i(hwrite),
    .ahb_s0_hsize_i (hsize),
    .ahb_s0_htrans_i(htrans),
    .ahb_s0_hwdata_i(hwdata),
    .ahb_s0_hready_o(hready),
    .ahb_s0_hresp_o (hresp),
    .ahb_s0_hrdata_o(hrdata),
    .ext_input_io   (ext_in),
    .ext_output_io  (ext_out),
    .ext_oe_o       (ext_oe),
    .irq_o          (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
  endtask

  // Returns #1 after the write edge, so the write has taken effect.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [2:0] size);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b1; hsize = size;
    @(negedge clk);
    bus_idle();
    hwdata = data;
    @(posedge clk);
    #1;
  endtask

  // Samples hrdata in the middle of the data phase.
  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = 1'b0; hsize = 3'b010;
    @(negedge clk);
    bus_idle();
    data = hrdata;
  endtask

  initial begin
    resetn = 1'b0;
    bus_idle();
    haddr  = '0;
    hsize  = 3'b010;
    hwdata = '0;
    ext_in = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out", {24'h0, ext_out}, 32'h0);
    check("rst_oe", {24'h0, ext_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_hready", {31'h0, hready}, 32'h1);
    check("rst_hresp", {31'h0, hresp}, 32'h0);
    check("rst_hrdata", hrdata, 32'h0);
    resetn = 1'b1;

    // Every offset reads 0 after reset
    for (int i = 0; i < 10; i++) begin
      ahb_read(32'(i * 4), rd);
      check($sformatf("rd0_ofs%02h", i * 4), rd, 32'h0);
    end

    // OUT / DIR / atomic set and clear
    ahb_write(32'h00, 32'h0000_00A5, 3'b010);
    ahb_write(32'h04, 32'h0000_000F, 3'b010);
    ahb_write(32'h1C, 32'h0000_0010, 3'b010);
    ahb_write(32'h20, 32'h0000_0001, 3'b010);
    check("out_pins", {24'h0, ext_out}, 32'hB4);
    check("oe_pins", {24'h0, ext_oe}, 32'h0F);
    ahb_read(32'h00, rd);
    check("rd_out", rd, 32'hB4);
    ahb_write(32'h00, 32'h0000_00FF, 3'b001);
    check("hw_write_ignored", {24'h0, ext_out}, 32'hB4);
    ahb_read(32'h1C, rd);
    check("rd_out_set", rd, 32'h0);

    // IN reflects pins with edges disabled
    @(negedge clk);
    ext_in = 8'h82;
    repeat (3) @(negedge clk);
    ahb_read(32'h08, rd);
    check("rd_in", rd, 32'h82);

    // Rising edge on pin0: STATUS after 3 edges, irq after 4
    ahb_write(32'h10, 32'h01, 3'b010);
    ahb_write(32'h0C, 32'h01, 3'b010);
    @(negedge clk);
    ext_in[0] = 1'b1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h18; hwrite = 1'b0; hsize = 3'b010;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      check($sformatf("rise_status_e%0d", e), hrdata, (e >= 3) ? 32'h1 : 32'h0);
      check($sformatf("rise_irq_e%0d", e), {31'h0, irq}, (e >= 4) ? 32'h1 : 32'h0);
      check($sformatf("hready_e%0d", e), {31'h0, hready}, 32'h1);
    end
    bus_idle();

    // W1C drops irq one edge after the write edge
    ahb_write(32'h18, 32'h01, 3'b010);
    check("w1c_irq_at_edge", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    check("w1c_irq_next", {31'h0, irq}, 32'h0);
    ahb_read(32'h18, rd);
    check("w1c_status", rd, 32'h0);

    // Falling edge on pin1 with IRQ_EN masking it
    ahb_write(32'h14, 32'h02, 3'b010);
    ahb_write(32'h0C, 32'h00, 3'b010);
    @(negedge clk);
    ext_in[1] = 1'b0;
    repeat (5) @(negedge clk);
    ahb_read(32'h18, rd);
    check("fall_status", rd, 32'h02);
    check("fall_irq_masked", {31'h0, irq}, 32'h0);
    ahb_write(32'h0C, 32'h02, 3'b010);
    check("en_irq_at_edge", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("en_irq_next", {31'h0, irq}, 32'h1);

    // W1C colliding with a fresh rising edge: set wins
    ahb_write(32'h18, 32'h02, 3'b010);
    ahb_write(32'h0C, 32'h01, 3'b010);
    @(negedge clk);
    ext_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    ext_in[0] = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_collide_irq", {31'h0, irq}, 32'h1);
    ext_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    ext_in[0] = 1'b1;                     // rise pulse lands on the 3rd edge
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h18; hwrite = 1'b1; hsize = 3'b010;
    @(negedge clk);
    bus_idle();
    hwdata = 32'h01;
    @(posedge clk);                       // write edge == edge 3
    #1;
    check("collide_irq_at_edge", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1;
    check("collide_irq_next", {31'h0, irq}, 32'h1);
    ahb_read(32'h18, rd);
    check("collide_status", rd, 32'h01);

    // Back-to-back write DIR then read DIR, then unmapped read
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h04; hwrite = 1'b1; hsize = 3'b010;
    @(negedge clk);
    hwdata = 32'h3C;
    haddr = 32'h04; hwrite = 1'b0;
    @(negedge clk);
    bus_idle();
    check("b2b_rd_dir", hrdata, 32'h3C);
    check("b2b_hready", {31'h0, hready}, 32'h1);
    check("b2b_oe", {24'h0, ext_oe}, 32'h3C);
    ahb_read(32'h24, rd);
    check("rd_unmapped_24", rd, 32'h0);

    // Reset in the middle of a write data phase
    @(negedge clk);
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h00; hwrite = 1'b1; hsize = 3'b010;
    @(negedge clk);
    bus_idle();
    hwdata = 32'hFF;
    resetn = 1'b0;
    #1;
    check("midrst_out", {24'h0, ext_out}, 32'h0);
    check("midrst_oe", {24'h0, ext_oe}, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_dropped", {24'h0, ext_out}, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    ahb_read(32'h00, rd);
    check("midrst_rd_out", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
